// File: rtl/gm_obj_pkg.sv
// Shared definitions for the object line scanner: position word layout,
// default sizes, the per-scanline hit entry and the scan FSM states.
package gm_obj_pkg;

  localparam int NUM_OBJ_DEF  = 37;
  localparam int MAX_HITS_DEF = 8;
  localparam int COORD_W_DEF  = 10;

  // Position word layout as exported by the Nios system
  localparam int POS_VALID_BIT = 31;
  localparam int POS_SIZE_LSB  = 24;
  localparam int POS_SIZE_W    = 6;
  localparam int POS_TYPE_LSB  = 20;
  localparam int POS_TYPE_W    = 4;
  localparam int POS_Y_LSB     = 10;
  localparam int POS_X_LSB     = 0;
  localparam int POS_XY_W      = 10;

  localparam int ID_W  = 6;
  localparam int OFS_W = 6;

  // One stored object on the upcoming scanline; 'used' marks a live slot
  typedef struct packed {
    logic                  used;
    logic [ID_W-1:0]       id;
    logic [POS_XY_W-1:0]   x;
    logic [POS_SIZE_W-1:0] size;
    logic [POS_TYPE_W-1:0] obj_type;
    logic [OFS_W-1:0]      oy;
  } hit_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/gm_hit_select.sv
// Per-pixel lookup: finds the lowest front slot covering px_x and registers
// the object id, type and in-object offsets for the sprite ROM.
module gm_hit_select
  import gm_obj_pkg::*;
#(
  parameter int MAX_HITS = MAX_HITS_DEF,
  parameter int COORD_W  = COORD_W_DEF
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  hit_entry_t [MAX_HITS-1:0]  entries,
  input  logic [COORD_W-1:0]         px_x,
  output logic                       hit_valid,
  output logic [ID_W-1:0]            hit_id,
  output logic [POS_TYPE_W-1:0]      hit_type,
  output logic [OFS_W-1:0]           hit_ox,
  output logic [OFS_W-1:0]           hit_oy
);

  logic                  hit_valid_q, hit_valid_d;
  logic [ID_W-1:0]       hit_id_q, hit_id_d;
  logic [POS_TYPE_W-1:0] hit_type_q, hit_type_d;
  logic [OFS_W-1:0]      hit_ox_q, hit_ox_d;
  logic [OFS_W-1:0]      hit_oy_q, hit_oy_d;
  logic [POS_XY_W:0]     px_ext;
  logic [POS_XY_W-1:0]   ox_full;
  logic                  unused_ox;

  assign px_ext    = (POS_XY_W+1)'(px_x);
  assign unused_ox = ^ox_full[POS_XY_W-1:OFS_W];

  // Priority match: walk from the top slot down so the lowest slot wins
  always_comb begin
    hit_valid_d = 1'b0;
    hit_id_d    = '0;
    hit_type_d  = '0;
    hit_ox_d    = '0;
    hit_oy_d    = '0;
    ox_full     = '0;
    for (int i = MAX_HITS-1; i >= 0; i--) begin
      if (entries[i].used
          && ({1'b0, entries[i].x} <= px_ext)
          && (px_ext < ({1'b0, entries[i].x} + (POS_XY_W+1)'(entries[i].size)))) begin
        ox_full     = POS_XY_W'(px_x) - entries[i].x;
        hit_valid_d = 1'b1;
        hit_id_d    = entries[i].id;
        hit_type_d  = entries[i].obj_type;
        hit_ox_d    = ox_full[OFS_W-1:0];
        hit_oy_d    = entries[i].oy;
      end
    end
  end

  // Output register gives the one-cycle lookup latency
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_valid_q <= 1'b0;
      hit_id_q    <= '0;
      hit_type_q  <= '0;
      hit_ox_q    <= '0;
      hit_oy_q    <= '0;
    end else begin
      hit_valid_q <= hit_valid_d;
      hit_id_q    <= hit_id_d;
      hit_type_q  <= hit_type_d;
      hit_ox_q    <= hit_ox_d;
      hit_oy_q    <= hit_oy_d;
    end
  end

  assign hit_valid = hit_valid_q;
  assign hit_id    = hit_id_q;
  assign hit_type  = hit_type_q;
  assign hit_ox    = hit_ox_q;
  assign hit_oy    = hit_oy_q;

endmodule

// File: rtl/gm_object_line_scanner.sv
// Object line scanner: snapshots Nios position words each frame, scans one
// object per cycle during horizontal blank into a back list, publishes it to
// the front list and answers per-pixel coverage queries from the front list.
module gm_object_line_scanner
  import gm_obj_pkg::*;
#(
  parameter int NUM_OBJ  = NUM_OBJ_DEF,
  parameter int MAX_HITS = MAX_HITS_DEF,
  parameter int COORD_W  = COORD_W_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_start,
  input  logic                   line_start,
  input  logic [COORD_W-1:0]     next_line,
  input  logic [NUM_OBJ*32-1:0]  pos_flat,
  input  logic [COORD_W-1:0]     px_x,
  output logic                   hit_valid,
  output logic [5:0]             hit_id,
  output logic [3:0]             hit_type,
  output logic [5:0]             hit_ox,
  output logic [5:0]             hit_oy,
  output logic                   scan_busy,
  output logic                   line_overflow
);

  localparam int IDX_W = $clog2(NUM_OBJ);
  localparam int CNT_W = $clog2(MAX_HITS + 1);

  logic [31:0]               shadow_q [NUM_OBJ];
  logic [31:0]               shadow_d [NUM_OBJ];
  scan_state_t               state_q, state_d;
  logic [COORD_W-1:0]        line_q, line_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      pend_ovf_q, pend_ovf_d;
  logic                      line_overflow_q, line_overflow_d;
  hit_entry_t [MAX_HITS-1:0] back_q, back_d;
  hit_entry_t [MAX_HITS-1:0] front_q, front_d;

  logic [31:0]               cur_word;
  logic [POS_SIZE_W-1:0]     cur_size;
  logic [POS_XY_W-1:0]       cur_y;
  logic [POS_XY_W:0]         y_ext;
  logic [POS_XY_W:0]         l_ext;
  logic [POS_XY_W-1:0]       oy_full;
  logic                      cur_hit;
  hit_entry_t                cur_entry;
  logic                      unused_scan;

  // Decode the object under the scan index against the latched line
  always_comb begin
    cur_word  = shadow_q[idx_q];
    cur_size  = cur_word[POS_SIZE_LSB +: POS_SIZE_W];
    cur_y     = cur_word[POS_Y_LSB +: POS_XY_W];
    y_ext     = {1'b0, cur_y};
    l_ext     = (POS_XY_W+1)'(line_q);
    cur_hit   = cur_word[POS_VALID_BIT]
                && (y_ext <= l_ext)
                && (l_ext < (y_ext + (POS_XY_W+1)'(cur_size)));
    oy_full   = POS_XY_W'(line_q) - cur_y;
    cur_entry          = '0;
    cur_entry.used     = 1'b1;
    cur_entry.id       = ID_W'(idx_q);
    cur_entry.x        = cur_word[POS_X_LSB +: POS_XY_W];
    cur_entry.size     = cur_size;
    cur_entry.obj_type = cur_word[POS_TYPE_LSB +: POS_TYPE_W];
    cur_entry.oy       = oy_full[OFS_W-1:0];
  end

  assign unused_scan = ^{cur_word[30], oy_full[POS_XY_W-1:OFS_W]};

  // Snapshot capture plus scan FSM next-state, list building and publishing
  always_comb begin
    shadow_d        = shadow_q;
    state_d         = state_q;
    line_d          = line_q;
    idx_d           = idx_q;
    count_d         = count_q;
    pend_ovf_d      = pend_ovf_q;
    line_overflow_d = line_overflow_q;
    back_d          = back_q;
    front_d         = front_q;

    if (frame_start) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow_d[i] = pos_flat[32*i +: 32];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (line_start) begin
          state_d    = ST_SCAN;
          line_d     = next_line;
          idx_d      = '0;
          count_d    = '0;
          pend_ovf_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (line_start) begin
          state_d    = ST_SCAN;
          line_d     = next_line;
          idx_d      = '0;
          count_d    = '0;
          pend_ovf_d = 1'b0;
        end else if (frame_start) begin
          state_d = ST_IDLE;
        end else begin
          if (cur_hit) begin
            if (count_q < CNT_W'(MAX_HITS)) begin
              for (int i = 0; i < MAX_HITS; i++) begin
                if (CNT_W'(i) == count_q) begin
                  back_d[i] = cur_entry;
                end
              end
              count_d = count_q + 1'b1;
            end else begin
              pend_ovf_d = 1'b1;
            end
          end
          if (idx_q == IDX_W'(NUM_OBJ - 1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (line_start) begin
          state_d    = ST_SCAN;
          line_d     = next_line;
          idx_d      = '0;
          count_d    = '0;
          pend_ovf_d = 1'b0;
        end else begin
          for (int i = 0; i < MAX_HITS; i++) begin
            front_d[i]      = back_q[i];
            front_d[i].used = (CNT_W'(i) < count_q);
          end
          line_overflow_d = pend_ovf_q;
          state_d         = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow_q        <= '{default: '0};
      state_q         <= ST_IDLE;
      line_q          <= '0;
      idx_q           <= '0;
      count_q         <= '0;
      pend_ovf_q      <= 1'b0;
      line_overflow_q <= 1'b0;
      back_q          <= '0;
      front_q         <= '0;
    end else begin
      shadow_q        <= shadow_d;
      state_q         <= state_d;
      line_q          <= line_d;
      idx_q           <= idx_d;
      count_q         <= count_d;
      pend_ovf_q      <= pend_ovf_d;
      line_overflow_q <= line_overflow_d;
      back_q          <= back_d;
      front_q         <= front_d;
    end
  end

  assign scan_busy     = (state_q != ST_IDLE);
  assign line_overflow = line_overflow_q;

  gm_hit_select #(
    .MAX_HITS (MAX_HITS),
    .COORD_W  (COORD_W)
  ) u_hit_select (
    .Clk       (Clk),
    .Reset     (Reset),
    .entries   (front_q),
    .px_x      (px_x),
    .hit_valid (hit_valid),
    .hit_id    (hit_id),
    .hit_type  (hit_type),
    .hit_ox    (hit_ox),
    .hit_oy    (hit_oy)
  );

endmodule
